// File: rtl/riscv_pkg.sv
// Shared types for the core's pipeline registers.
//  - per-stage control bundles (callers pack them into preg_stage's ctrl port)
//  - the NOP control value for each stage boundary (no writes, no memory access)
//  - preg_state_e: occupancy of a preg_stage
//  - $bits-derived widths so instantiations follow the struct definitions
package riscv_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } preg_state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_imm;
        logic       illegal;
    } dec_ctrl_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic [1:0] op_sel;
        logic       branch;
    } ex_ctrl_t;

    typedef struct packed {
        logic       rd_en;
        logic       wr_en;
        logic [1:0] size;
        logic       unsigned_ld;
    } mem_ctrl_t;

    typedef struct packed {
        logic       rf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    localparam int DEC_CTRL_W = $bits(dec_ctrl_t);
    localparam int EX_CTRL_W  = $bits(ex_ctrl_t);
    localparam int MEM_CTRL_W = $bits(mem_ctrl_t);
    localparam int WB_CTRL_W  = $bits(wb_ctrl_t);

    // Control carried across each boundary: everything still needed downstream.
    localparam int IFDEC_CTRL_W = DEC_CTRL_W;
    localparam int DECEX_CTRL_W = EX_CTRL_W + MEM_CTRL_W + WB_CTRL_W;
    localparam int EXMEM_CTRL_W = MEM_CTRL_W + WB_CTRL_W;
    localparam int MEMWB_CTRL_W = WB_CTRL_W;

    localparam logic [IFDEC_CTRL_W-1:0] IFDEC_NOP_CTRL = '0;
    localparam logic [DECEX_CTRL_W-1:0] DECEX_NOP_CTRL = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_NOP_CTRL = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_NOP_CTRL = '0;

endpackage

// File: rtl/preg_slot.sv
// One pipeline-register entry: valid bit plus payload and control.
//  clk, rst_n     clock, synchronous active-low reset (clears everything)
//  vld_d          next value of the valid bit (written every cycle)
//  load           capture data_d/ctrl_d; payload holds otherwise
//  data_d,ctrl_d  incoming payload / control
//  vld,data,ctrl  registered entry
module preg_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_d,
    input  logic              load,
    input  logic [DATA_W-1:0] data_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    output logic              vld,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            data <= '0;
            ctrl <= '0;
        end else begin
            vld <= vld_d;
            if (load) begin
                data <= data_d;
                ctrl <= ctrl_d;
            end
        end
    end

endmodule

// File: rtl/preg_stage.sv
// Generic pipeline register between core stages with valid/ready handshake,
// optional 2-entry skid, flush and NOP-control bubbles.
//  clk, rst_n                 clock, synchronous active-low reset
//  flush_i                    drop every held entry and any same-cycle input
//  in_valid_i/in_ready_o      upstream handshake, in_data_i/in_ctrl_i payload
//  out_valid_o/out_ready_i    downstream handshake, out_data_o/out_ctrl_o head
//  occ_o                      entries held (0..2)
//  stall_cnt_o                saturating count of cycles head valid but not taken
module preg_stage
    import riscv_pkg::*;
#(
    parameter int                 DATA_W   = 64,
    parameter int                 CTRL_W   = 16,
    parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    preg_state_e       state_q, state_d;
    logic              main_valid, skid_valid;
    logic [DATA_W-1:0] main_data, skid_data, main_data_d;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_d;
    logic              main_load, skid_load, main_from_skid;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    main_load = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (in_xfer && SKID != 0) begin
                    state_d   = FULL;
                    skid_load = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Skid drains into main; input is blocked, keeping FIFO order.
                if (out_xfer) begin
                    state_d        = ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush discards the same-cycle input too, so nothing is captured.
        if (flush_i) begin
            state_d        = EMPTY;
            main_load      = 1'b0;
            skid_load      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    assign main_data_d = main_from_skid ? skid_data : in_data_i;
    assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl_i;

    preg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_d  (state_d != EMPTY),
        .load   (main_load),
        .data_d (main_data_d),
        .ctrl_d (main_ctrl_d),
        .vld    (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            preg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .vld_d  (state_d == FULL),
                .load   (skid_load),
                .data_d (in_data_i),
                .ctrl_d (in_ctrl_i),
                .vld    (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );
            // Registered ready: only depends on the skid entry being free.
            assign in_ready_o = rst_n & ~skid_valid;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_data  = '0;
            assign skid_ctrl  = '0;
            assign in_ready_o = rst_n & (out_ready_i | ~main_valid);
        end
    endgenerate

    assign out_valid_o = main_valid;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = (rst_n & main_valid) ? main_ctrl : NOP_CTRL;
    assign occ_o       = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (out_valid_o && !out_ready_i && stall_cnt_o != CNT_MAX)
            stall_cnt_o <= stall_cnt_o + 1'b1;
    end

endmodule
